inst_prefetch_queue: RTL and testbench

//  Parametrised next-generation instruction fetch stage for the RV32 core.

---
 rtl/inst_prefetch_queue_if.sv | 28 ++
 rtl/inst_prefetch_queue.sv | 122 ++++++++++++
 tb/tb_inst_prefetch_queue.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_prefetch_queue_if.sv
// rtl/inst_prefetch_queue_if.sv - fetch-stage bundle: redirect, memory req/gnt/rvld port, decode delivery
interface inst_prefetch_queue_if #(
  parameter int AW = 32,
  parameter int CW = 3
);
  logic          jmp_vld;
  logic [AW-1:0] jmp_addr;
  logic          hold;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_gnt;
  logic          mem_rvld;
  logic [31:0]   mem_rdata;
  logic          IF_vld;
  logic [AW-1:0] IF_pc;
  logic [31:0]   IF_inst;
  logic [CW-1:0] IF_count;

  modport master (
    input  jmp_vld, jmp_addr, hold, mem_gnt, mem_rvld, mem_rdata,
    output mem_req, mem_addr, IF_vld, IF_pc, IF_inst, IF_count
  );

  modport slave (
    output jmp_vld, jmp_addr, hold, mem_gnt, mem_rvld, mem_rdata,
    input  mem_req, mem_addr, IF_vld, IF_pc, IF_inst, IF_count
  );
endinterface

// File: rtl/inst_prefetch_queue.sv
// rtl/inst_prefetch_queue.sv - in-order instruction prefetch queue with redirect flush
module inst_prefetch_queue #(
  parameter int              AW       = 32,
  parameter int              DEPTH    = 4,
  parameter logic [AW-1:0]   RESET_PC = '0,
  parameter logic [31:0]     NOP_INST = 32'h0000_0013
) (
  input  logic                 clk,
  input  logic                 rst,
  inst_prefetch_queue_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [AW-1:0]    pc_q [DEPTH];
  logic [AW-1:0]    pc_d [DEPTH];
  logic [31:0]      inst_q [DEPTH];
  logic [31:0]      inst_d [DEPTH];
  logic [DEPTH-1:0] filled_q, filled_d;
  logic [PW-1:0]    alloc_ptr_q, alloc_ptr_d;
  logic [PW-1:0]    fill_ptr_q, fill_ptr_d;
  logic [PW-1:0]    head_ptr_q, head_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    out_q, out_d;
  logic [CW-1:0]    discard_q, discard_d;
  logic [AW-1:0]    fetch_pc_q, fetch_pc_d;
  logic             run_q, run_d;
  logic             head_vld, issue, fill, pop;

  // Requests are held back while stale responses drain so the credit count stays exact.
  assign head_vld     = filled_q[head_ptr_q];
  assign bus.mem_req  = run_q && (count_q != FULL) && !bus.jmp_vld && (discard_q == '0);
  assign bus.mem_addr = fetch_pc_q;
  assign issue        = bus.mem_req && bus.mem_gnt;
  assign fill         = bus.mem_rvld && (discard_q == '0) && !bus.jmp_vld;
  assign pop          = head_vld && !bus.hold && !bus.jmp_vld;

  assign bus.IF_vld   = head_vld;
  assign bus.IF_pc    = head_vld ? pc_q[head_ptr_q] : '0;
  assign bus.IF_inst  = head_vld ? inst_q[head_ptr_q] : NOP_INST;
  assign bus.IF_count = count_q;

  always_comb begin
    pc_d        = pc_q;
    inst_d      = inst_q;
    filled_d    = filled_q;
    alloc_ptr_d = alloc_ptr_q;
    fill_ptr_d  = fill_ptr_q;
    head_ptr_d  = head_ptr_q;
    count_d     = count_q;
    out_d       = out_q;
    discard_d   = discard_q;
    fetch_pc_d  = fetch_pc_q;
    run_d       = 1'b1;
    if (bus.jmp_vld) begin
      // Every fetch still owed by memory becomes a response to throw away.
      filled_d    = '0;
      alloc_ptr_d = '0;
      fill_ptr_d  = '0;
      head_ptr_d  = '0;
      count_d     = '0;
      out_d       = '0;
      discard_d   = discard_q + out_q - CW'(bus.mem_rvld);
      fetch_pc_d  = bus.jmp_addr;
    end else begin
      if (fill) begin
        inst_d[fill_ptr_q]   = bus.mem_rdata;
        filled_d[fill_ptr_q] = 1'b1;
        fill_ptr_d           = fill_ptr_q + PW'(1);
      end
      if (pop) begin
        filled_d[head_ptr_q] = 1'b0;
        head_ptr_d           = head_ptr_q + PW'(1);
      end
      if (issue) begin
        pc_d[alloc_ptr_q]     = fetch_pc_q;
        filled_d[alloc_ptr_q] = 1'b0;
        alloc_ptr_d           = alloc_ptr_q + PW'(1);
        fetch_pc_d            = fetch_pc_q + AW'(4);
      end
      if (bus.mem_rvld && (discard_q != '0)) begin
        discard_d = discard_q - CW'(1);
      end
      count_d = count_q + CW'(issue) - CW'(pop);
      out_d   = out_q + CW'(issue) - CW'(fill);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        inst_q[i] <= '0;
      end
      filled_q    <= '0;
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      head_ptr_q  <= '0;
      count_q     <= '0;
      out_q       <= '0;
      discard_q   <= '0;
      fetch_pc_q  <= RESET_PC;
      run_q       <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      filled_q    <= filled_d;
      alloc_ptr_q <= alloc_ptr_d;
      fill_ptr_q  <= fill_ptr_d;
      head_ptr_q  <= head_ptr_d;
      count_q     <= count_d;
      out_q       <= out_d;
      discard_q   <= discard_d;
      fetch_pc_q  <= fetch_pc_d;
      run_q       <= run_d;
    end
  end

  a_rvld_outstanding: assert property (@(posedge clk) disable iff (rst)
    !(bus.mem_rvld && (out_q == '0) && (discard_q == '0)));
endmodule

// File: tb/tb_inst_prefetch_queue.sv
// tb/tb_inst_prefetch_queue.sv - bench: queue-level reference model plus directed fetch/jump/reset scenarios
module tb_inst_prefetch_queue;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'hFFFF_FFF8;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  inst_prefetch_queue_if #(.AW(32), .CW(3)) bus ();

  inst_prefetch_queue #(.AW(32), .DEPTH(DEPTH), .RESET_PC(RPC), .NOP_INST(NOP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_pass = 0;
  int n_total = 0;
  bit cmp_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
  endtask

  // Memory: answers grants in order after a programmable latency, one response per cycle.
  typedef struct { logic [31:0] data; int due; } rsp_t;
  rsp_t pend[$];
  int   cyc = 0;
  int   lat = 1;
  bit   poison = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h5A00_0000 | {8'h00, a[23:0]};
  endfunction

  always @(posedge clk) begin
    if (!rst && bus.mem_req && bus.mem_gnt)
      pend.push_back('{poison ? 32'hDEAD_BEEF : mem_word(bus.mem_addr), cyc + lat});
    cyc++;
    #2;
    if (rst) begin
      pend.delete();
      bus.mem_rvld  = 1'b0;
      bus.mem_rdata = '0;
    end else if (pend.size() > 0 && pend[0].due <= cyc) begin
      bus.mem_rvld  = 1'b1;
      bus.mem_rdata = pend[0].data;
      void'(pend.pop_front());
    end else begin
      bus.mem_rvld  = 1'b0;
      bus.mem_rdata = '0;
    end
  end

  // Reference model: an ordered list of allocated fetches plus a count of responses to drop.
  typedef struct { logic [31:0] pc; logic [31:0] inst; bit filled; } ent_t;
  ent_t        mq[$];
  logic [31:0] m_pc   = RPC;
  int          m_disc = 0;
  bit          m_run  = 0;
  bit          m_pop, m_issue;
  int          m_unf;

  function automatic bit m_req();
    return m_run && (mq.size() < DEPTH) && !bus.jmp_vld && (m_disc == 0);
  endfunction

  function automatic bit m_vld();
    return (mq.size() > 0) && mq[0].filled;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_pc   = RPC;
      m_disc = 0;
      m_run  = 0;
    end else begin
      m_issue = m_req() && bus.mem_gnt;
      if (bus.jmp_vld) begin
        m_unf = 0;
        foreach (mq[i]) if (!mq[i].filled) m_unf++;
        m_disc = m_disc + m_unf - (bus.mem_rvld ? 1 : 0);
        mq.delete();
        m_pc = bus.jmp_addr;
      end else begin
        m_pop = m_vld() && !bus.hold;
        if (bus.mem_rvld) begin
          if (m_disc > 0) m_disc--;
          else begin
            for (int i = 0; i < mq.size(); i++) begin
              if (!mq[i].filled) begin
                mq[i].inst   = bus.mem_rdata;
                mq[i].filled = 1;
                break;
              end
            end
          end
        end
        if (m_pop) void'(mq.pop_front());
        if (m_issue) begin
          mq.push_back('{m_pc, 32'h0, 1'b0});
          m_pc = m_pc + 32'd4;
        end
      end
      m_run = 1;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("mem_req", {31'b0, bus.mem_req}, {31'b0, m_req()});
      chk("mem_addr", bus.mem_addr, m_pc);
      chk("IF_vld", {31'b0, bus.IF_vld}, {31'b0, m_vld()});
      chk("IF_pc", bus.IF_pc, m_vld() ? mq[0].pc : 32'h0);
      chk("IF_inst", bus.IF_inst, m_vld() ? mq[0].inst : NOP);
      chk("IF_count", {29'b0, bus.IF_count}, 32'(mq.size()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_vld(input logic [31:0] pc, input string nm);
    bit found;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      #1;
      found = bus.IF_vld;
    end
    chk({nm, "_seen"}, {31'b0, found}, 32'd1);
    chk({nm, "_pc"}, bus.IF_pc, pc);
    chk({nm, "_inst"}, bus.IF_inst, mem_word(pc));
  endtask

  initial begin
    bus.jmp_vld   = 1'b0;
    bus.jmp_addr  = '0;
    bus.hold      = 1'b0;
    bus.mem_gnt   = 1'b0;
    bus.mem_rvld  = 1'b0;
    bus.mem_rdata = '0;
    tick(); tick();
    cmp_en = 1;
    tick(); #1;
    chk("rst_req", {31'b0, bus.mem_req}, 32'd0);
    chk("rst_vld", {31'b0, bus.IF_vld}, 32'd0);
    chk("rst_pc", bus.IF_pc, 32'd0);
    chk("rst_inst", bus.IF_inst, NOP);
    chk("rst_count", {29'b0, bus.IF_count}, 32'd0);

    // Streaming from a reset pc just below the top of the address space.
    rst = 1'b0;
    bus.mem_gnt = 1'b1;
    tick(); #1;
    chk("rel_req", {31'b0, bus.mem_req}, 32'd1);
    chk("rel_addr", bus.mem_addr, 32'hFFFF_FFF8);
    tick(); #1; chk("wrap_a1", bus.mem_addr, 32'hFFFF_FFFC);
    tick(); #1; chk("wrap_a2", bus.mem_addr, 32'h0000_0000);
    chk("wrap_p0", bus.IF_pc, 32'hFFFF_FFF8);
    tick(); #1; chk("wrap_a3", bus.mem_addr, 32'h0000_0004);
    chk("wrap_p1", bus.IF_pc, 32'hFFFF_FFFC);
    tick(); #1; chk("wrap_p2", bus.IF_pc, 32'h0000_0000);
    chk("wrap_a4", bus.mem_addr, 32'h0000_0008);
    repeat (4) tick();

    // Redirect to 0 with decode stalled: fill to DEPTH, then drain in order.
    bus.hold = 1'b1;
    bus.jmp_vld = 1'b1;
    bus.jmp_addr = 32'h0;
    #1; chk("jmp_req_off", {31'b0, bus.mem_req}, 32'd0);
    tick();
    bus.jmp_vld = 1'b0;
    #1; chk("j0_req", {31'b0, bus.mem_req}, 32'd1);
    chk("j0_addr", bus.mem_addr, 32'h0);
    repeat (4) tick();
    #1; chk("full_count", {29'b0, bus.IF_count}, 32'd4);
    chk("full_req", {31'b0, bus.mem_req}, 32'd0);
    chk("full_pc", bus.IF_pc, 32'h0);
    chk("full_vld", {31'b0, bus.IF_vld}, 32'd1);
    tick(); tick();
    bus.hold = 1'b0;
    #1; chk("drain_p0", bus.IF_pc, 32'h0);
    tick(); #1; chk("drain_p1", bus.IF_pc, 32'h4);
    chk("resume_req", {31'b0, bus.mem_req}, 32'd1);
    chk("resume_addr", bus.mem_addr, 32'h10);
    tick(); #1; chk("drain_p2", bus.IF_pc, 32'h8);
    tick(); #1; chk("drain_p3", bus.IF_pc, 32'hC);
    repeat (4) tick();

    bus.mem_gnt = 1'b0;
    repeat (10) tick();
    #1; chk("empty_count", {29'b0, bus.IF_count}, 32'd0);
    chk("empty_inst", bus.IF_inst, NOP);

    // Two stale fetches in flight when the redirect arrives.
    lat = 3;
    poison = 1;
    bus.mem_gnt = 1'b1;
    tick(); tick();
    bus.mem_gnt = 1'b0;
    bus.jmp_vld = 1'b1;
    bus.jmp_addr = 32'h100;
    #1; chk("j100_req_off", {31'b0, bus.mem_req}, 32'd0);
    chk("j100_count", {29'b0, bus.IF_count}, 32'd2);
    tick();
    bus.jmp_vld = 1'b0;
    poison = 0;
    bus.mem_gnt = 1'b1;
    wait_vld(32'h100, "j100");

    // Redirect coinciding with a response, then two redirects back to back.
    lat = 2;
    repeat (8) tick();
    bus.jmp_vld = 1'b1;
    bus.jmp_addr = 32'h200;
    tick();
    bus.jmp_vld = 1'b0;
    wait_vld(32'h200, "j200");
    repeat (6) tick();
    bus.jmp_vld = 1'b1;
    bus.jmp_addr = 32'h300;
    tick();
    bus.jmp_addr = 32'h400;
    tick();
    bus.jmp_vld = 1'b0;
    wait_vld(32'h400, "j400");

    // Reset in the middle of streaming.
    repeat (4) tick();
    @(posedge clk);
    #1 rst = 1'b1;
    #2;
    chk("mid_rst_req", {31'b0, bus.mem_req}, 32'd0);
    chk("mid_rst_vld", {31'b0, bus.IF_vld}, 32'd0);
    chk("mid_rst_inst", bus.IF_inst, NOP);
    chk("mid_rst_count", {29'b0, bus.IF_count}, 32'd0);
    tick();
    rst = 1'b0;
    tick(); #1;
    chk("rerel_req", {31'b0, bus.mem_req}, 32'd1);
    chk("rerel_addr", bus.mem_addr, RPC);
    repeat (6) tick();

    cmp_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
